// File: rtl/tinyalu_ctl_pkg.sv
// Shared types and constants for blocks that front the tinyalu datapath.
package tinyalu_ctl_pkg;

  typedef enum logic [2:0] {
    NO_OP  = 3'b000,
    ADD_OP = 3'b001,
    AND_OP = 3'b010,
    XOR_OP = 3'b011,
    MUL_OP = 3'b100
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  localparam logic [15:0] ERR_RESULT_DEF = 16'hDEAD;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);

  logic [IW-1:0] idx;

  always_comb begin
    // NOTE: every variable gets a default before the search so no path leaves it unassigned.
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Shares one tinyalu between N_REQ requesters: round-robin grant, start held until done or
// timeout, and a one-cycle result strobe back to the owning requester only.
module tinyalu_arbiter
  import tinyalu_ctl_pkg::*;
#(
  parameter int          N_REQ       = 4,
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [15:0] ERR_RESULT  = ERR_RESULT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [3*N_REQ-1:0] req_op,
  input  logic [8*N_REQ-1:0] req_a,
  input  logic [8*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [15:0]        resp_result,
  output logic               resp_err,
  output logic               alu_start,
  output logic [2:0]         alu_op,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  input  logic               alu_done,
  input  logic [15:0]        alu_result,
  output logic               busy
);

  localparam int               IW  = $clog2(N_REQ);
  localparam int               CW  = $clog2(TIMEOUT_CYC);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  arb_state_t       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    cap_id;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_id;
  logic             gnt_any;
  logic [2:0]       win_op;
  logic [7:0]       win_a;
  logic [7:0]       win_b;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req    (req_valid),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  assign win_op = req_op[3*gnt_id +: 3];
  assign win_a  = req_a[8*gnt_id +: 8];
  assign win_b  = req_b[8*gnt_id +: 8];

  // The accept pulse is the only Mealy output; it is masked while reset is held.
  assign req_ready = (state == IDLE && !reset) ? gnt : '0;
  assign busy      = (state != IDLE);

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the ALU operand registers are reset too, since they drive output pins directly.
      state       <= IDLE;
      ptr         <= '0;
      cap_id      <= '0;
      cnt         <= '0;
      resp_valid  <= '0;
      resp_result <= '0;
      resp_err    <= 1'b0;
      alu_start   <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            cap_id <= gnt_id;
            if (win_op == NO_OP) begin
              state       <= RESP;
              resp_valid  <= gnt;
              resp_result <= '0;
              resp_err    <= 1'b0;
            end else begin
              state     <= BUSY;
              alu_start <= 1'b1;
              alu_op    <= win_op;
              alu_a     <= win_a;
              alu_b     <= win_b;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          // done takes priority over a timeout landing in the same cycle
          if (alu_done) begin
            state       <= RESP;
            alu_start   <= 1'b0;
            resp_valid  <= ONE << cap_id;
            resp_result <= alu_result;
            resp_err    <= 1'b0;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            state       <= RESP;
            alu_start   <= 1'b0;
            resp_valid  <= ONE << cap_id;
            resp_result <= ERR_RESULT;
            resp_err    <= 1'b1;
          end
        end
        RESP: begin
          state       <= IDLE;
          cnt         <= '0;
          resp_valid  <= '0;
          resp_result <= '0;
          resp_err    <= 1'b0;
          ptr         <= (cap_id == IW'(N_REQ - 1)) ? '0 : cap_id + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_tinyalu_arbiter;
  import tinyalu_ctl_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid, req_ready, resp_valid;
  logic [3*N-1:0]   req_op;
  logic [8*N-1:0]   req_a, req_b;
  logic [15:0]      resp_result, alu_result;
  logic             resp_err, alu_start, alu_done, busy;
  logic [2:0]       alu_op;
  logic [7:0]       alu_a, alu_b;

  always #5 clk = ~clk;

  tinyalu_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO), .ERR_RESULT(16'hDEAD)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_err(resp_err),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // requester side
  bit         pend [N];
  logic [2:0] p_op [N];
  logic [7:0] p_a  [N];
  logic [7:0] p_b  [N];
  int         waited [N];
  logic [N-1:0] accepted = '0;
  bit refill = 0, rand_issue = 0, rand_drop = 0, rand_ops = 0;

  // ALU side
  bit spurious = 0;
  int hang_mode = 0;   // 0 never, 1 always, 2 occasionally
  int lat_force = 0;   // 0 = random latency 1..4

  // transaction in flight
  bit         outstanding = 0, in_resp = 0, cur_hang = 0;
  int         cur_id = 0, cur_lat = 1, start_cycles = 0, since_accept = 0;
  logic [2:0] cur_op = '0;
  logic [7:0] cur_a = '0, cur_b = '0;
  int         model_ptr = 0;
  int         n_resp = 0;
  int         grant_log [$];
  logic [15:0] last_res [N];
  bit          last_err [N];
  int          last_starts [N];
  bit drv_reset = 1, rst_at_edge = 0;

  function automatic logic [15:0] alu_fn(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return {a, b};
    endcase
  endfunction

  function automatic int exp_winner();
    for (int k = 0; k < N; k++)
      if (pend[(model_ptr + k) % N]) return (model_ptr + k) % N;
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic new_op(int i);
    pend[i]   = 1'b1;
    p_op[i]   = rand_ops ? 3'($urandom_range(0, 7)) : 3'(ADD_OP);
    p_a[i]    = 8'($urandom);
    p_b[i]    = 8'($urandom);
    waited[i] = 0;
  endtask

  task automatic issue(int i, logic [2:0] op, logic [7:0] a, logic [7:0] b);
    pend[i] = 1'b1; p_op[i] = op; p_a[i] = a; p_b[i] = b; waited[i] = 0;
  endtask

  task automatic observe_outputs();
    logic [15:0] er;
    logic        ee;
    int          es;
    if (rst_at_edge) begin
      check("rst_resp_valid", resp_valid, 0);
      check("rst_alu_start", alu_start, 0);
      check("rst_busy", busy, 0);
      check("rst_resp_result", resp_result, 0);
      check("rst_resp_err", resp_err, 0);
      outstanding = 0; in_resp = 0; model_ptr = 0; since_accept = 0;
      for (int i = 0; i < N; i++) waited[i] = 0;
      return;
    end
    in_resp = 0;
    check("busy", busy, outstanding);
    if (outstanding) since_accept++;
    if (alu_start) begin
      start_cycles++;
      check("start_owner", outstanding, 1);
      check("alu_op", alu_op, cur_op);
      check("alu_a", alu_a, cur_a);
      check("alu_b", alu_b, cur_b);
    end
    if (resp_valid != 0) begin
      check("resp_expected", outstanding, 1);
      check("resp_owner", resp_valid, N'(1) << cur_id);
      if (cur_op == 3'(NO_OP)) begin er = 16'h0; ee = 1'b0; es = 0; end
      else if (cur_hang)       begin er = 16'hDEAD; ee = 1'b1; es = TO; end
      else                     begin er = alu_fn(cur_op, cur_a, cur_b); ee = 1'b0; es = cur_lat; end
      check("resp_result", resp_result, er);
      check("resp_err", resp_err, ee);
      check("start_cycles", start_cycles, es);
      if (cur_op == 3'(NO_OP)) check("noop_latency", since_accept, 1);
      last_res[cur_id]    = resp_result;
      last_err[cur_id]    = resp_err;
      last_starts[cur_id] = start_cycles;
      model_ptr   = (cur_id + 1) % N;
      outstanding = 0;
      in_resp     = 1;
      n_resp++;
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (accepted[i]) begin
        pend[i] = 1'b0;
        if (refill) new_op(i);
      end else if (pend[i] && rand_drop && $urandom_range(0, 31) == 0) begin
        pend[i] = 1'b0;
      end else if (!pend[i] && rand_issue && $urandom_range(0, 7) == 0) begin
        new_op(i);
      end
      req_valid[i]      = pend[i];
      req_op[3*i +: 3]  = p_op[i];
      req_a[8*i +: 8]   = p_a[i];
      req_b[8*i +: 8]   = p_b[i];
    end
    accepted = '0;
  endtask

  task automatic drive_alu();
    if (alu_start && !cur_hang && start_cycles == cur_lat) begin
      alu_done   = 1'b1;
      alu_result = alu_fn(alu_op, alu_a, alu_b);
    end else begin
      alu_done   = (spurious && !alu_start) ? ($urandom_range(0, 3) == 0) : 1'b0;
      alu_result = 16'($urandom);
    end
  endtask

  task automatic observe_grant();
    logic [N-1:0] exp_mask;
    int           w;
    exp_mask = '0;
    w = -1;
    if (!reset && !outstanding && !in_resp) w = exp_winner();
    if (w >= 0) exp_mask[w] = 1'b1;
    check("req_ready", req_ready, exp_mask);
    if (w >= 0) begin
      check("fair_wait", waited[w] <= N - 1, 1);
      for (int i = 0; i < N; i++) if (i != w && pend[i]) waited[i]++;
      waited[w]    = 0;
      accepted[w]  = 1'b1;
      outstanding  = 1;
      cur_id       = w;
      cur_op       = p_op[w];
      cur_a        = p_a[w];
      cur_b        = p_b[w];
      cur_hang     = (hang_mode == 1) || (hang_mode == 2 && $urandom_range(0, 15) == 0);
      cur_lat      = (lat_force != 0) ? lat_force : $urandom_range(1, 4);
      start_cycles = 0;
      since_accept = 0;
      grant_log.push_back(w);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    rst_at_edge = reset;
    observe_outputs();
    drive_reqs();
    drive_alu();
    reset = drv_reset;
    #1;
    observe_grant();
  endtask

  task automatic run_until_quiet(string tag, int max_cyc);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while ((any_pend() || outstanding || in_resp) && n < max_cyc);
    check({tag, "_drained"}, any_pend() || outstanding || in_resp, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, n;
    reset = 1'b1; alu_done = 1'b0; alu_result = '0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; p_op[i] = '0; p_a[i] = '0; p_b[i] = '0; waited[i] = 0;
      last_res[i] = '0; last_err[i] = 0; last_starts[i] = 0;
    end

    // reset: a pending request must not be accepted while reset is held
    issue(1, ADD_OP, 8'h01, 8'h02);
    repeat (3) cycle();
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_req_ready", req_ready, 0);
    drv_reset = 0;
    run_until_quiet("t0", 50);
    check("t0_result", last_res[1], 16'h0003);

    // 1: single ADD on port 0
    issue(0, ADD_OP, 8'h12, 8'h34);
    run_until_quiet("t1", 50);
    check("t1_result", last_res[0], 16'h0046);
    check("t1_err", last_err[0], 0);

    // 2: long MUL on port 2 while port 0 waits
    lat_force = 4;
    issue(2, MUL_OP, 8'hFF, 8'hFF);
    issue(0, XOR_OP, 8'hA5, 8'h0F);
    run_until_quiet("t2", 60);
    lat_force = 0;
    check("t2_mul", last_res[2], 16'hFE01);
    check("t2_mul_starts", last_starts[2], 4);
    check("t2_xor", last_res[0], 16'h00AA);

    // park the pointer at 0, then 3: all four ports continuously valid
    issue(3, AND_OP, 8'hF0, 8'h3C);
    run_until_quiet("t3pre", 50);
    check("t3pre_and", last_res[3], 16'h0030);
    grant_log.delete();
    refill = 1;
    for (int i = 0; i < N; i++) new_op(i);
    n = 0;
    while (grant_log.size() < 5 && n < 200) begin cycle(); n++; end
    refill = 0;
    run_until_quiet("t3", 200);
    check("t3_grants", grant_log.size() >= 5, 1);
    if (grant_log.size() >= 5) begin
      check("t3_g0", grant_log[0], 0);
      check("t3_g1", grant_log[1], 1);
      check("t3_g2", grant_log[2], 2);
      check("t3_g3", grant_log[3], 3);
      check("t3_g4", grant_log[4], 0);
    end

    // 4: NO_OP on port 1
    issue(1, NO_OP, 8'h77, 8'h88);
    run_until_quiet("t4", 20);
    check("t4_result", last_res[1], 16'h0000);
    check("t4_no_start", last_starts[1], 0);

    // 5: ALU never answers, then normal service resumes
    hang_mode = 1;
    issue(3, ADD_OP, 8'h10, 8'h20);
    run_until_quiet("t5", 80);
    hang_mode = 0;
    check("t5_err", last_err[3], 1);
    check("t5_result", last_res[3], 16'hDEAD);
    check("t5_busy_cycles", last_starts[3], TO);
    issue(0, ADD_OP, 8'h80, 8'h80);
    run_until_quiet("t5b", 50);
    check("t5b_result", last_res[0], 16'h0100);
    check("t5b_err", last_err[0], 0);

    // 6: reset in the middle of a MUL
    issue(1, ADD_OP, 8'h05, 8'h06);
    run_until_quiet("t6pre", 50);
    lat_force = 10;
    issue(2, MUL_OP, 8'h11, 8'h11);
    n = 0;
    while (!alu_start && n < 20) begin cycle(); n++; end
    check("t6_busy_seen", alu_start, 1);
    cycle();
    snap = n_resp;
    drv_reset = 1;
    cycle();
    drv_reset = 0;
    cycle();
    check("t6_start_dropped", alu_start, 0);
    repeat (3) cycle();
    check("t6_no_resp", n_resp, snap);
    lat_force = 0;
    grant_log.delete();
    issue(3, ADD_OP, 8'h21, 8'h43);
    issue(0, ADD_OP, 8'h0A, 8'h0B);
    run_until_quiet("t6", 60);
    check("t6_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    check("t6_add", last_res[0], 16'h0015);
    check("t6_add3", last_res[3], 16'h0064);

    // randomized traffic: drops, all op codes, stray done pulses, occasional hangs
    snap = n_resp;
    rand_issue = 1; rand_drop = 1; rand_ops = 1; spurious = 1; hang_mode = 2;
    repeat (1500) cycle();
    rand_issue = 0; rand_drop = 0;
    run_until_quiet("rand", 400);
    spurious = 0; hang_mode = 0;
    check("rand_progress", n_resp - snap > 50, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
